// File: rtl/split_target_mem.sv
// split_target_mem: byte-wide memory target on the serial bus.
// Writes complete with a single ack. Reads are either answered on the next
// cycle or deferred through split: split_ack, a fixed internal latency,
// split_req, and completion when the arbiter grants the bus back.
module split_target_mem #(
    parameter logic [15:0] BASE_ADDR    = 16'h4000,
    parameter int          MEM_SIZE     = 4096,
    parameter int          READ_LATENCY = 4,
    parameter bit          SPLIT_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] target_addr_in,
    input  logic        target_addr_in_valid,
    input  logic [7:0]  target_data_in,
    input  logic        target_data_in_valid,
    input  logic        target_rw,
    input  logic        split_grant,
    output logic        split_req,
    output logic [7:0]  target_data_out,
    output logic        target_data_out_valid,
    output logic        target_ack,
    output logic        target_split_ack,
    output logic        target_ready,
    output logic [7:0]  split_target_last_write
);

    localparam int IDX_W = $clog2(MEM_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WDATA,
        READ_WAIT,
        SPLIT_REQ
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             in_range_q, in_range_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             split_req_q, split_req_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             data_out_valid_q, data_out_valid_d;
    logic             ack_q, ack_d;
    logic             split_ack_q, split_ack_d;
    logic             ready_q, ready_d;
    logic [7:0]       last_write_q, last_write_d;

    logic [7:0]       mem [MEM_SIZE];
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [7:0]       mem_wdata;

    logic [16:0]      dec_offset;
    logic             dec_in_range;
    logic [IDX_W-1:0] dec_idx;

    // Address decode: 17-bit offset so addresses below the base cannot alias into range.
    always_comb begin
        dec_offset   = {1'b0, target_addr_in} - {1'b0, BASE_ADDR};
        dec_in_range = (target_addr_in >= BASE_ADDR) && (dec_offset < 17'(MEM_SIZE));
        dec_idx      = dec_offset[IDX_W-1:0];
    end

    // Storage array; written only on a committed in-range write.
    // NOTE: the memory has no reset branch -- contents survive rst_n and a
    // reset loop over the array would prevent mapping onto RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Next-state and registered-output logic for the transaction FSM.
    // NOTE: every _d signal gets its default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        in_range_d       = in_range_q;
        cnt_d            = cnt_q;
        rd_data_d        = rd_data_q;
        split_req_d      = split_req_q;
        data_out_d       = data_out_q;
        data_out_valid_d = 1'b0;
        ack_d            = 1'b0;
        split_ack_d      = 1'b0;
        last_write_d     = last_write_q;
        mem_we           = 1'b0;
        mem_waddr        = idx_q;
        mem_wdata        = target_data_in;

        unique case (state_q)
            IDLE: begin
                if (target_addr_in_valid) begin
                    idx_d      = dec_idx;
                    in_range_d = dec_in_range;
                    if (target_rw) begin
                        if (target_data_in_valid) begin
                            if (dec_in_range) begin
                                mem_we       = 1'b1;
                                mem_waddr    = dec_idx;
                                last_write_d = target_data_in;
                            end
                            ack_d = 1'b1;
                        end else begin
                            state_d = WAIT_WDATA;
                        end
                    end else if (!dec_in_range) begin
                        data_out_d       = 8'h00;
                        data_out_valid_d = 1'b1;
                        ack_d            = 1'b1;
                    end else if (!SPLIT_ENABLE) begin
                        data_out_d       = mem[dec_idx];
                        data_out_valid_d = 1'b1;
                        ack_d            = 1'b1;
                    end else begin
                        split_ack_d = 1'b1;
                        cnt_d       = 8'(READ_LATENCY);
                        rd_data_d   = mem[dec_idx];
                        state_d     = READ_WAIT;
                    end
                end
            end
            WAIT_WDATA: begin
                if (target_data_in_valid) begin
                    if (in_range_q) begin
                        mem_we       = 1'b1;
                        last_write_d = target_data_in;
                    end
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            READ_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    cnt_d       = 8'd0;
                    split_req_d = 1'b1;
                    state_d     = SPLIT_REQ;
                end
            end
            SPLIT_REQ: begin
                if (split_grant) begin
                    split_req_d      = 1'b0;
                    data_out_d       = rd_data_q;
                    data_out_valid_d = 1'b1;
                    ack_d            = 1'b1;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and output registers; reset aborts any transaction silently.
    // NOTE: non-blocking assignments keep every register updating from the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            idx_q            <= '0;
            in_range_q       <= 1'b0;
            cnt_q            <= 8'd0;
            rd_data_q        <= 8'h00;
            split_req_q      <= 1'b0;
            data_out_q       <= 8'h00;
            data_out_valid_q <= 1'b0;
            ack_q            <= 1'b0;
            split_ack_q      <= 1'b0;
            ready_q          <= 1'b0;
            last_write_q     <= 8'h00;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            in_range_q       <= in_range_d;
            cnt_q            <= cnt_d;
            rd_data_q        <= rd_data_d;
            split_req_q      <= split_req_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            ack_q            <= ack_d;
            split_ack_q      <= split_ack_d;
            ready_q          <= ready_d;
            last_write_q     <= last_write_d;
        end
    end

    assign split_req               = split_req_q;
    assign target_data_out         = data_out_q;
    assign target_data_out_valid   = data_out_valid_q;
    assign target_ack              = ack_q;
    assign target_split_ack        = split_ack_q;
    assign target_ready            = ready_q;
    assign split_target_last_write = last_write_q;

endmodule

// File: tb/tb_split_target_mem.sv
// Bench for split_target_mem: a split-enabled and a split-disabled instance
// share one stimulus stream. Expected responses are queued at issue time from
// a byte-array memory model and popped by a monitor whenever a DUT responds.
module tb_split_target_mem;

    localparam logic [15:0] BASE  = 16'h4000;
    localparam int          MSIZE = 4096;
    localparam int          LAT   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr_in;
    logic        addr_valid;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        rw_in;
    logic        split_grant;

    logic       s_req, s_valid, s_ack, s_sack, s_ready;
    logic [7:0] s_dout, s_lw;
    logic       n_req, n_valid, n_ack, n_sack, n_ready;
    logic [7:0] n_dout, n_lw;

    split_target_mem #(.BASE_ADDR(BASE), .MEM_SIZE(MSIZE), .READ_LATENCY(LAT), .SPLIT_ENABLE(1'b1)) u_split (
        .clk(clk), .rst_n(rst_n),
        .target_addr_in(addr_in), .target_addr_in_valid(addr_valid),
        .target_data_in(data_in), .target_data_in_valid(data_valid),
        .target_rw(rw_in), .split_grant(split_grant),
        .split_req(s_req), .target_data_out(s_dout), .target_data_out_valid(s_valid),
        .target_ack(s_ack), .target_split_ack(s_sack), .target_ready(s_ready),
        .split_target_last_write(s_lw)
    );

    split_target_mem #(.BASE_ADDR(BASE), .MEM_SIZE(MSIZE), .READ_LATENCY(LAT), .SPLIT_ENABLE(1'b0)) u_nosplit (
        .clk(clk), .rst_n(rst_n),
        .target_addr_in(addr_in), .target_addr_in_valid(addr_valid),
        .target_data_in(data_in), .target_data_in_valid(data_valid),
        .target_rw(rw_in), .split_grant(split_grant),
        .split_req(n_req), .target_data_out(n_dout), .target_data_out_valid(n_valid),
        .target_ack(n_ack), .target_split_ack(n_sack), .target_ready(n_ready),
        .split_target_last_write(n_lw)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind = {split_ack, ack, data_out_valid}; at = expected cycle, -1 when grant-dependent
    typedef struct {
        logic [2:0] kind;
        bit         has_data;
        logic [7:0] data;
        logic [7:0] lw;
        int         at;
    } exp_t;

    exp_t q_s[$];
    exp_t q_n[$];

    logic [7:0] mm [MSIZE];
    bit         wr_seen [MSIZE];
    logic [7:0] lw_model = 8'h00;

    int checks = 0;
    int errors = 0;

    bit grant_auto = 1'b0;
    int grant_cyc  = -1;
    bit prev_req   = 1'b0;
    bit prev_grant = 1'b0;
    int sack_cyc   = 0;
    bit n_req_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic score(input bit is_split, input logic [2:0] kind, input logic [7:0] dat,
                         input logic [7:0] lw, input logic req);
        exp_t  e;
        string nm;
        nm = is_split ? "split" : "nosplit";
        if (is_split ? (q_s.size() == 0) : (q_n.size() == 0)) begin
            check({nm, "_unexpected_response"}, 32'(kind), 32'd0);
            return;
        end
        e = is_split ? q_s.pop_front() : q_n.pop_front();
        check({nm, "_kind"}, 32'(kind), 32'(e.kind));
        if (e.at >= 0) check({nm, "_latency"}, cyc, e.at);
        else check({nm, "_grant_handshake"}, 32'({prev_req, prev_grant, req}), 32'(3'b110));
        if (e.has_data) check({nm, "_rdata"}, 32'(dat), 32'(e.data));
        if (e.kind == 3'b010) check({nm, "_last_write"}, 32'(lw), 32'(e.lw));
    endtask

    // Monitor: pop and compare on every response strobe, track split_req timing.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_ack || s_valid || s_sack) score(1'b1, {s_sack, s_ack, s_valid}, s_dout, s_lw, s_req);
            if (n_ack || n_valid || n_sack) score(1'b0, {n_sack, n_ack, n_valid}, n_dout, n_lw, n_req);
            if (n_req) n_req_seen = 1'b1;
            if (s_sack) sack_cyc = cyc;
            if (s_req && !prev_req) check("split_req_latency", cyc - sack_cyc, LAT);
            prev_req   = s_req;
            prev_grant = split_grant;
        end else begin
            prev_req   = 1'b0;
            prev_grant = 1'b0;
        end
    end

    // Grant driver: random in auto mode, a single scheduled cycle otherwise.
    initial begin
        split_grant = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (grant_auto) split_grant = s_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            else split_grant = (cyc == grant_cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!(s_ready && n_ready)) begin
            n++;
            if (n > 400) begin
                check("ready_timeout", 32'({s_ready, n_ready}), 32'(2'b11));
                return;
            end
            tick();
        end
    endtask

    task automatic push_write(input bit inr, input int idx, input logic [7:0] data);
        exp_t e;
        if (inr) begin
            mm[idx]      = data;
            wr_seen[idx] = 1'b1;
            lw_model     = data;
        end
        e = '{kind: 3'b010, has_data: 1'b0, data: 8'h00, lw: lw_model, at: cyc + 1};
        q_s.push_back(e);
        q_n.push_back(e);
    endtask

    // Issue one transaction; returns one cycle after the address strobe
    // (writes: one cycle after the data strobe). t0 is the address cycle.
    task automatic issue(input logic rw, input logic [15:0] addr, input logic [7:0] data,
                         input int delay, output int t0);
        bit         inr;
        int         idx;
        logic [7:0] d;
        exp_t       e;
        wait_ready();
        inr = (int'(addr) >= int'(BASE)) && (int'(addr) - int'(BASE) < MSIZE);
        idx = inr ? int'(addr) - int'(BASE) : 0;
        t0  = cyc;
        addr_in    = addr;
        addr_valid = 1'b1;
        rw_in      = rw;
        data_in    = data;
        data_valid = rw && (delay == 0);
        if (!rw) begin
            d = inr ? mm[idx] : 8'h00;
            e = '{kind: 3'b011, has_data: (!inr || wr_seen[idx]), data: d, lw: 8'h00, at: cyc + 1};
            q_n.push_back(e);
            if (inr) begin
                q_s.push_back('{kind: 3'b100, has_data: 1'b0, data: 8'h00, lw: 8'h00, at: cyc + 1});
                e.at = -1;
            end
            q_s.push_back(e);
            tick();
            addr_valid = 1'b0;
        end else begin
            if (delay > 0) begin
                tick();
                addr_valid = 1'b0;
                for (int i = 1; i < delay; i++) begin
                    check("ready_low_in_wait_wdata", 32'({s_ready, n_ready}), 32'd0);
                    if ($urandom_range(0, 1) == 1) begin
                        addr_valid = 1'b1;
                        addr_in    = 16'($urandom);
                        rw_in      = 1'($urandom);
                    end
                    tick();
                    addr_valid = 1'b0;
                end
                check("ready_low_in_wait_wdata", 32'({s_ready, n_ready}), 32'd0);
                data_valid = 1'b1;
            end
            push_write(inr, idx, data);
            tick();
            addr_valid = 1'b0;
            data_valid = 1'b0;
        end
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 9))
            0:       return 16'(int'(BASE) - 1);
            1:       return 16'(int'(BASE) + MSIZE - 1);
            2:       return 16'(int'(BASE) + MSIZE);
            3:       return 16'hFFFF;
            4:       return 16'h0000;
            default: return 16'(int'(BASE) + $urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        int t0;
        int n;
        rst_n      = 1'b0;
        addr_in    = 16'h0000;
        addr_valid = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;
        rw_in      = 1'b0;

        // Reset values of every output on both instances.
        #12;
        check("reset_outputs_split", 32'({s_req, s_dout, s_valid, s_ack, s_sack, s_ready, s_lw}), 32'd0);
        check("reset_outputs_nosplit", 32'({n_req, n_dout, n_valid, n_ack, n_sack, n_ready, n_lw}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Write with both strobes in one cycle; ready never drops.
        issue(1'b1, 16'h4010, 8'hA5, 0, t0);
        check("ready_stays_high", 32'({s_ready, n_ready}), 32'(2'b11));
        check("last_write_a5", 32'(s_lw), 32'(8'hA5));

        // Write whose data follows three cycles after the address.
        issue(1'b1, 16'h4011, 8'h3C, 3, t0);

        // Split read with the grant held off until T+9.
        issue(1'b0, 16'h4010, 8'h00, 0, t0);
        grant_cyc = t0 + 9;
        check("split_ack_t1", 32'(s_sack), 32'd1);
        while (cyc < t0 + 4) tick();
        check("split_req_low_t4", 32'(s_req), 32'd0);
        tick();
        check("split_req_high_t5", 32'(s_req), 32'd1);
        while (cyc < t0 + 9) tick();
        check("split_req_held_t9", 32'(s_req), 32'd1);
        tick();
        check("split_done_t10", 32'({s_ack, s_valid, s_dout, s_req}), 32'({1'b1, 1'b1, 8'hA5, 1'b0}));

        // Remaining directed cases run with a randomly behaving arbiter.
        grant_auto = 1'b1;
        issue(1'b0, 16'h4011, 8'h00, 0, t0);
        issue(1'b0, 16'h5000, 8'h00, 0, t0);
        issue(1'b1, 16'h4FFF, 8'h77, 0, t0);
        issue(1'b1, 16'h3FFF, 8'h99, 2, t0);
        issue(1'b0, 16'h4FFF, 8'h00, 0, t0);
        wait_ready();

        // Reset while the split instance waits in SPLIT_REQ.
        grant_auto = 1'b0;
        grant_cyc  = -1;
        tick();
        issue(1'b0, 16'h4FFF, 8'h00, 0, t0);
        n = 0;
        while (!s_req && n < 50) begin
            tick();
            n++;
        end
        check("split_req_before_reset", 32'(s_req), 32'd1);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_clears_split_req", 32'({s_req, s_ack, s_valid, s_ready}), 32'd0);
        q_s.delete();
        q_n.delete();
        lw_model = 8'h00;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        grant_auto = 1'b1;
        issue(1'b0, 16'h4FFF, 8'h00, 0, t0);
        wait_ready();

        // Randomised traffic.
        for (int k = 0; k < 200; k++) begin
            issue(1'($urandom), pick_addr(), 8'($urandom), $urandom_range(0, 3), t0);
        end
        wait_ready();
        repeat (5) tick();

        check("split_queue_drained", q_s.size(), 0);
        check("nosplit_queue_drained", q_n.size(), 0);
        check("nosplit_never_split_req", 32'(n_req_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
